// File: rtl/sa_ram_pkg.sv
// -----------------------------------------------------------------------------
// sa_ram_pkg
//   Shared definitions for the sa_ram family of RAM models.
//   - BYTE         : lane width used by byte write masks
//   - sa_ram_aw    : address width for a given depth, never below 1 bit
//   - merge_bytes  : one-lane byte merge (new lane where mask set, else old)
// -----------------------------------------------------------------------------
package sa_ram_pkg;

    localparam int unsigned BYTE = 8;

    function automatic int unsigned sa_ram_aw(input int unsigned depth);
        int unsigned aw;
        aw = $clog2(depth);
        return (aw < 1) ? 1 : aw;
    endfunction

    // Applied lane by lane so it works for any WIDTH that is a multiple of BYTE.
    function automatic logic [BYTE-1:0] merge_bytes(
        input logic [BYTE-1:0] old_b,
        input logic [BYTE-1:0] new_b,
        input logic            mask
    );
        return mask ? new_b : old_b;
    endfunction

endpackage

// File: rtl/sa_ram_bmsk_array.sv
// -----------------------------------------------------------------------------
// sa_ram_bmsk_array
//   Storage only: byte-masked synchronous write, asynchronous read.
//   Kept free of pipeline registers so the array infers as LUTRAM/BRAM.
//   Ports:
//     clk    in  clock
//     we     in  write enable, already qualified as in range by the caller
//     wa     in  write address
//     wmask  in  byte write mask (bit i covers di[8i+7:8i])
//     di     in  write data
//     ra_d   in  registered read address
//     rdata  out M[ra_d], or zero when ra_d is beyond DEPTH
// -----------------------------------------------------------------------------
module sa_ram_bmsk_array
    import sa_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 61,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = sa_ram_aw(DEPTH),
    parameter int unsigned MW    = WIDTH / BYTE
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [MW-1:0]    wmask,
    input  logic [WIDTH-1:0] di,
    input  logic [AW-1:0]    ra_d,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < MW; i++) begin
                if (wmask[i]) begin
                    mem[wa][i*BYTE +: BYTE] <= di[i*BYTE +: BYTE];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if ({1'b0, ra_d} < DEPTH_C) begin
            rdata = mem[ra_d];
        end
    end

endmodule

// File: rtl/sa_ram_rwsp_bmsk.sv
// -----------------------------------------------------------------------------
// sa_ram_rwsp_bmsk
//   Parametrised 1R/1W RAM model with two-stage read (re registers the
//   address, ore registers the data), per-byte write mask, optional
//   write-to-read forwarding at the output stage, read-valid tracking and a
//   sticky out-of-range address error.
//   Ports:
//     clk            in  clock
//     rstn           in  asynchronous active-low reset
//     ra/re          in  read address / read-address enable
//     ore            in  output-register enable
//     dout           out registered read data
//     dout_vld       out dout holds data of a read launched since last capture
//     wa/we          in  write address / write enable
//     wmask          in  byte write mask
//     di             in  write data
//     err_oob        out sticky out-of-range address flag
//     pwrbus_ram_pd  in  power-down bus, ignored
// -----------------------------------------------------------------------------
module sa_ram_rwsp_bmsk
    import sa_ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 61,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned AW     = sa_ram_aw(DEPTH),
    parameter int unsigned MW     = WIDTH / BYTE,
    parameter int unsigned BYPASS = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [MW-1:0]    wmask,
    input  logic [WIDTH-1:0] di,
    output logic             err_oob,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic             wa_ok;
    logic             ra_ok;
    logic             fwd;
    logic [AW-1:0]    ra_d;
    logic             rd_pend;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] dout_nxt;
    logic             unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign wa_ok = ({1'b0, wa} < DEPTH_C);
    assign ra_ok = ({1'b0, ra} < DEPTH_C);

    sa_ram_bmsk_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW),
        .MW    (MW)
    ) u_array (
        .clk   (clk),
        .we    (we && wa_ok),
        .wa    (wa),
        .wmask (wmask),
        .di    (di),
        .ra_d  (ra_d),
        .rdata (rdata)
    );

    // Stage 1: address register and pending-read tracking. A new re takes
    // priority over the ore that would otherwise retire the pending read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_d    <= '0;
            rd_pend <= 1'b0;
        end else if (re) begin
            ra_d    <= ra;
            rd_pend <= 1'b1;
        end else if (ore) begin
            rd_pend <= 1'b0;
        end
    end

    // Forwarding only needs wa==ra_d with wa in range; that also implies
    // ra_d is in range, so rdata is the real array word being merged.
    assign fwd = (BYPASS != 0) && we && wa_ok && (wa == ra_d);

    always_comb begin
        dout_nxt = rdata;
        if (fwd) begin
            for (int unsigned i = 0; i < MW; i++) begin
                dout_nxt[i*BYTE +: BYTE] = merge_bytes(rdata[i*BYTE +: BYTE],
                                                       di[i*BYTE +: BYTE],
                                                       wmask[i]);
            end
        end
    end

    // Stage 2: output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (ore) begin
            dout     <= dout_nxt;
            dout_vld <= rd_pend;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_oob <= 1'b0;
        end else if ((we && !wa_ok) || (re && !ra_ok)) begin
            err_oob <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sa_ram_rwsp_bmsk.sv
// -----------------------------------------------------------------------------
// tb_sa_ram_rwsp_bmsk
//   Drives two instances (BYPASS=1 and BYPASS=0) with identical stimulus.
//   A behavioural model predicts the post-edge outputs of every cycle and
//   queues them; a monitor pops and compares one entry after every edge.
// -----------------------------------------------------------------------------
module tb_sa_ram_rwsp_bmsk;
    import sa_ram_pkg::*;

    localparam int unsigned DEPTH = 61;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned AW    = sa_ram_aw(DEPTH);
    localparam int unsigned MW    = WIDTH / 8;

    typedef struct packed {
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d0;
        logic             vld;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [AW-1:0]    wa;
    logic             we;
    logic [MW-1:0]    wmask;
    logic [WIDTH-1:0] di;
    logic [31:0]      pwrbus_ram_pd;
    logic [WIDTH-1:0] dout1, dout0;
    logic             vld1, vld0, err1, err0;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_ra_d;
    bit               m_pend;
    logic [WIDTH-1:0] m_d1, m_d0;
    bit               m_vld, m_err;

    sa_ram_rwsp_bmsk #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BYPASS(1)) dut (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
        .dout(dout1), .dout_vld(vld1), .wa(wa), .we(we), .wmask(wmask),
        .di(di), .err_oob(err1), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    sa_ram_rwsp_bmsk #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BYPASS(0)) dut0 (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
        .dout(dout0), .dout_vld(vld0), .wa(wa), .we(we), .wmask(wmask),
        .di(di), .err_oob(err0), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("dout_bypass1", dout1, mon_e.d1);
            chk("dout_bypass0", dout0, mon_e.d0);
            chk("dout_vld_b1", {{(WIDTH-1){1'b0}}, vld1}, {{(WIDTH-1){1'b0}}, mon_e.vld});
            chk("dout_vld_b0", {{(WIDTH-1){1'b0}}, vld0}, {{(WIDTH-1){1'b0}}, mon_e.vld});
            chk("err_oob_b1", {{(WIDTH-1){1'b0}}, err1}, {{(WIDTH-1){1'b0}}, mon_e.err});
            chk("err_oob_b0", {{(WIDTH-1){1'b0}}, err0}, {{(WIDTH-1){1'b0}}, mon_e.err});
        end
    end

    // Apply one cycle of stimulus and predict the state after the next edge.
    task automatic step(input logic r_n, input logic re_i, input logic [AW-1:0] ra_i,
                        input logic ore_i, input logic we_i, input logic [AW-1:0] wa_i,
                        input logic [MW-1:0] wm_i, input logic [WIDTH-1:0] di_i);
        logic [WIDTH-1:0] old;
        int unsigned      wai;
        @(negedge clk);
        rstn = r_n; re = re_i; ra = ra_i; ore = ore_i;
        we = we_i; wa = wa_i; wmask = wm_i; di = di_i;
        pwrbus_ram_pd = $urandom;
        wai = wa_i;
        if (!r_n) begin
            m_ra_d = 0; m_pend = 0; m_d1 = '0; m_d0 = '0; m_vld = 0; m_err = 0;
        end else begin
            if (ore_i) begin
                old  = (m_ra_d < DEPTH) ? m_mem[m_ra_d] : '0;
                m_d1 = old;
                m_d0 = old;
                if (we_i && wai < DEPTH && wai == m_ra_d) begin
                    for (int b = 0; b < MW; b++)
                        if (wm_i[b]) m_d1[8*b +: 8] = di_i[8*b +: 8];
                end
                m_vld = m_pend;
            end
            if (re_i) begin
                m_ra_d = ra_i;
                m_pend = 1;
            end else if (ore_i) begin
                m_pend = 0;
            end
            if ((we_i && wai >= DEPTH) || (re_i && int'(ra_i) >= DEPTH)) m_err = 1;
            if (we_i && wai < DEPTH) begin
                for (int b = 0; b < MW; b++)
                    if (wm_i[b]) m_mem[wai][8*b +: 8] = di_i[8*b +: 8];
            end
        end
        exp_q.push_back('{d1: m_d1, d0: m_d0, vld: m_vld, err: m_err});
    endtask

    task automatic idle();
        step(1, 0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic rd(input int unsigned a);
        step(1, 1, AW'(a), 0, 0, '0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a_r, a_w;
        rstn = 0; re = 0; ra = '0; ore = 0; we = 0; wa = '0; wmask = '0; di = '0;
        pwrbus_ram_pd = '0;

        // Reset values
        step(0, 0, '0, 0, 0, '0, '0, '0);
        step(0, 0, '0, 0, 0, '0, '0, '0);

        // Full write then two-stage read
        step(1, 0, '0, 0, 1, AW'(5), 8'hFF, 64'h0123456789ABCDEF);
        rd(5);
        // Masked write, unmasked bytes kept
        step(1, 0, '0, 0, 1, AW'(5), 8'h0F, '1);
        rd(5);

        // Forwarding on the ore edge
        step(1, 0, '0, 0, 1, AW'(7), 8'hFF, '0);
        step(1, 1, AW'(7), 0, 0, '0, '0, '0);
        step(1, 0, '0, 1, 1, AW'(7), 8'hF0, {8{8'hAA}});
        rd(7);
        // Write on the edge before ore is visible to both variants
        step(1, 1, AW'(7), 0, 1, AW'(7), 8'h0F, {8{8'h55}});
        step(1, 0, '0, 1, 0, '0, '0, '0);

        // Prefill M[i]=i, then stream one read per cycle
        for (int i = 0; i < DEPTH; i++) step(1, 0, '0, 0, 1, AW'(i), 8'hFF, 64'(i));
        for (int i = 0; i < DEPTH; i++) step(1, 1, AW'(i), 1, 0, '0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0, '0);

        // Random in-range traffic, biased toward write/read address collisions
        for (int n = 0; n < 400; n++) begin
            a_r = AW'($urandom_range(0, DEPTH - 1));
            a_w = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 2) == 0) a_w = m_ra_d[AW-1:0];
            step(1, 1'($urandom), a_r, 1'($urandom), 1'($urandom), a_w,
                 MW'($urandom), {$urandom, $urandom});
        end
        idle();

        // Out-of-range write dropped, out-of-range read returns zero, sticky flag
        step(1, 0, '0, 0, 1, AW'(DEPTH), 8'hFF, {$urandom, $urandom});
        idle();
        rd(63);
        for (int i = 0; i < DEPTH; i += 6) rd(i);
        rd(DEPTH - 1);

        // Reset between re and ore discards the pending read
        step(1, 1, AW'(3), 0, 0, '0, '0, '0);
        step(0, 0, '0, 1, 0, '0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0, '0);
        step(1, 0, '0, 1, 0, '0, '0, '0);
        rd(3);
        idle();

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
